// File: rtl/itch_parser_v2.sv
// ITCH 5.0 message parser: decodes A/F/D/E/X/U from a byte stream, with an
// optional per-locate channel filter and truncation/overflow/unknown-type error pulses.
module itch_parser_v2 #(
    parameter int unsigned NUM_LOCATES   = 4,
    parameter int unsigned FILTER_EN     = 1,
    parameter int unsigned MAX_PKT_BYTES = 2048
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [7:0]                    dataIn,
    input  logic                          dataValidIn,
    input  logic                          packetLostIn,
    input  logic [16*NUM_LOCATES-1:0]     locateTableIn,
    input  logic [NUM_LOCATES-1:0]        locateEnIn,
    output logic                          addValidOut,
    output logic                          delValidOut,
    output logic                          execValidOut,
    output logic                          cancelValidOut,
    output logic                          replaceValidOut,
    output logic [63:0]                   refNumOut,
    output logic [63:0]                   newRefNumOut,
    output logic [15:0]                   locateOut,
    output logic [31:0]                   sharesOut,
    output logic [31:0]                   priceOut,
    output logic                          buySellOut,
    output logic [$clog2(NUM_LOCATES > 1 ? NUM_LOCATES : 2)-1:0] chanOut,
    output logic                          errTruncOut,
    output logic                          errOverflowOut,
    output logic                          errUnknownOut
);

    localparam int unsigned CW = $clog2(NUM_LOCATES > 1 ? NUM_LOCATES : 2);
    localparam int unsigned PW = $clog2(MAX_PKT_BYTES + 1) + 1;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DROP} state_t;

    state_t        state;
    logic [5:0]    idx;
    logic [5:0]    len;
    logic [7:0]    mtype;
    logic [PW-1:0] pkt_cnt;
    logic [63:0]   ref_q, ref_n, nref_q, nref_n;
    logic [15:0]   loc_q, loc_n;
    logic [31:0]   sh_q, sh_n, pr_q, pr_n;
    logic          side_q, side_n;
    logic          match_q, match_n;
    logic [CW-1:0] chan_q, chan_n;
    logic          is_af, is_u, is_ex, is_d, last, overflow;

    function automatic logic [5:0] msg_len(input logic [7:0] t);
        case (t)
            8'h41:   return 6'd36;
            8'h46:   return 6'd40;
            8'h44:   return 6'd19;
            8'h45:   return 6'd31;
            8'h58:   return 6'd23;
            8'h55:   return 6'd35;
            default: return 6'd0;
        endcase
    endfunction

    // Field shifters: each field takes the current byte while idx is inside its offsets
    always_comb begin
        is_af    = (mtype == 8'h41) || (mtype == 8'h46);
        is_u     = (mtype == 8'h55);
        is_d     = (mtype == 8'h44);
        is_ex    = (mtype == 8'h45) || (mtype == 8'h58);
        last     = (idx == len - 6'd1);
        overflow = dataValidIn && (pkt_cnt == PW'(MAX_PKT_BYTES));
        loc_n    = loc_q;
        ref_n    = ref_q;
        nref_n   = nref_q;
        sh_n     = sh_q;
        pr_n     = pr_q;
        side_n   = side_q;
        if (idx >= 6'd1 && idx <= 6'd2)   loc_n = {loc_q[7:0], dataIn};
        if (idx >= 6'd11 && idx <= 6'd18) ref_n = {ref_q[55:0], dataIn};
        if (is_af) begin
            if (idx == 6'd19)                 side_n = (dataIn == 8'h42);
            if (idx >= 6'd20 && idx <= 6'd23) sh_n   = {sh_q[23:0], dataIn};
            if (idx >= 6'd32 && idx <= 6'd35) pr_n   = {pr_q[23:0], dataIn};
        end
        if (is_ex && idx >= 6'd19 && idx <= 6'd22) sh_n = {sh_q[23:0], dataIn};
        if (is_u) begin
            if (idx >= 6'd19 && idx <= 6'd26) nref_n = {nref_q[55:0], dataIn};
            if (idx >= 6'd27 && idx <= 6'd30) sh_n   = {sh_q[23:0], dataIn};
            if (idx >= 6'd31 && idx <= 6'd34) pr_n   = {pr_q[23:0], dataIn};
        end
        match_n = (FILTER_EN == 0);
        chan_n  = '0;
        // Descending scan so the lowest matching entry wins
        if (FILTER_EN != 0) begin
            for (int i = NUM_LOCATES - 1; i >= 0; i--) begin
                if (locateEnIn[i] && locateTableIn[16*i +: 16] == loc_n) begin
                    match_n = 1'b1;
                    chan_n  = CW'(i);
                end
            end
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state           <= IDLE;
            idx             <= '0;
            len             <= '0;
            mtype           <= '0;
            pkt_cnt         <= '0;
            ref_q           <= '0;
            nref_q          <= '0;
            loc_q           <= '0;
            sh_q            <= '0;
            pr_q            <= '0;
            side_q          <= 1'b0;
            match_q         <= 1'b0;
            chan_q          <= '0;
            addValidOut     <= 1'b0;
            delValidOut     <= 1'b0;
            execValidOut    <= 1'b0;
            cancelValidOut  <= 1'b0;
            replaceValidOut <= 1'b0;
            refNumOut       <= '0;
            newRefNumOut    <= '0;
            locateOut       <= '0;
            sharesOut       <= '0;
            priceOut        <= '0;
            buySellOut      <= 1'b0;
            chanOut         <= '0;
            errTruncOut     <= 1'b0;
            errOverflowOut  <= 1'b0;
            errUnknownOut   <= 1'b0;
        end else begin
            addValidOut     <= 1'b0;
            delValidOut     <= 1'b0;
            execValidOut    <= 1'b0;
            cancelValidOut  <= 1'b0;
            replaceValidOut <= 1'b0;
            errTruncOut     <= 1'b0;
            errOverflowOut  <= 1'b0;
            errUnknownOut   <= 1'b0;

            // Saturating packet byte count, cleared in every gap
            if (!dataValidIn)                        pkt_cnt <= '0;
            else if (pkt_cnt <= PW'(MAX_PKT_BYTES))  pkt_cnt <= pkt_cnt + PW'(1);

            if (packetLostIn) begin
                state <= DROP;
            end else begin
                case (state)
                    IDLE: begin
                        if (dataValidIn) begin
                            if (overflow) begin
                                errOverflowOut <= 1'b1;
                                state          <= DROP;
                            end else if (msg_len(dataIn) != 6'd0) begin
                                mtype <= dataIn;
                                len   <= msg_len(dataIn);
                                idx   <= 6'd1;
                                state <= HDR;
                            end else begin
                                errUnknownOut <= 1'b1;
                                state         <= DROP;
                            end
                        end
                    end
                    HDR, BODY: begin
                        if (!dataValidIn) begin
                            errTruncOut <= 1'b1;
                            state       <= IDLE;
                        end else if (overflow) begin
                            errOverflowOut <= 1'b1;
                            state          <= DROP;
                        end else begin
                            loc_q  <= loc_n;
                            ref_q  <= ref_n;
                            nref_q <= nref_n;
                            sh_q   <= sh_n;
                            pr_q   <= pr_n;
                            side_q <= side_n;
                            if (idx == 6'd2) begin
                                match_q <= match_n;
                                chan_q  <= chan_n;
                            end
                            if (last) begin
                                state <= IDLE;
                                if (match_q) begin
                                    addValidOut     <= is_af;
                                    delValidOut     <= is_d;
                                    execValidOut    <= (mtype == 8'h45);
                                    cancelValidOut  <= (mtype == 8'h58);
                                    replaceValidOut <= is_u;
                                    refNumOut       <= ref_n;
                                    newRefNumOut    <= is_u ? nref_n : 64'd0;
                                    locateOut       <= loc_q;
                                    sharesOut       <= is_d ? 32'd0 : sh_n;
                                    priceOut        <= (is_af || is_u) ? pr_n : 32'd0;
                                    buySellOut      <= is_af && side_n;
                                    chanOut         <= chan_q;
                                end
                            end else begin
                                idx   <= idx + 6'd1;
                                state <= (idx >= 6'd18) ? BODY : HDR;
                            end
                        end
                    end
                    DROP: begin
                        if (!dataValidIn) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_itch_parser_v2.sv
// Directed bench for itch_parser_v2: messages are built byte-wise, expected
// decodes are queued as stimulus is built and popped as valids appear.
module tb_itch_parser_v2;

    localparam int unsigned NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    dataIn;
    logic          dataValidIn;
    logic          packetLostIn;
    logic [16*NL-1:0] locateTableIn;
    logic [NL-1:0] locateEnIn;
    logic          addValidOut, delValidOut, execValidOut, cancelValidOut, replaceValidOut;
    logic [63:0]   refNumOut, newRefNumOut;
    logic [15:0]   locateOut;
    logic [31:0]   sharesOut, priceOut;
    logic          buySellOut;
    logic [1:0]    chanOut;
    logic          errTruncOut, errOverflowOut, errUnknownOut;

    always #5 clk = ~clk;

    itch_parser_v2 #(.NUM_LOCATES(NL), .FILTER_EN(1), .MAX_PKT_BYTES(2048)) dut (
        .clkIn(clk), .rstIn(rst), .dataIn(dataIn), .dataValidIn(dataValidIn),
        .packetLostIn(packetLostIn), .locateTableIn(locateTableIn), .locateEnIn(locateEnIn),
        .addValidOut(addValidOut), .delValidOut(delValidOut), .execValidOut(execValidOut),
        .cancelValidOut(cancelValidOut), .replaceValidOut(replaceValidOut),
        .refNumOut(refNumOut), .newRefNumOut(newRefNumOut), .locateOut(locateOut),
        .sharesOut(sharesOut), .priceOut(priceOut), .buySellOut(buySellOut), .chanOut(chanOut),
        .errTruncOut(errTruncOut), .errOverflowOut(errOverflowOut), .errUnknownOut(errUnknownOut)
    );

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [2:0]  kind;
        logic [63:0] rf;
        logic [63:0] nrf;
        logic [15:0] loc;
        logic [31:0] sh;
        logic [31:0] pr;
        logic        bs;
        logic [1:0]  chan;
    } exp_t;

    exp_t    sb[$];
    byte_q_t pkt;
    int checks = 0, errors = 0;
    int n_valid = 0, n_trunc = 0, n_ovf = 0, n_unk = 0;
    int exp_valid = 0, exp_trunc = 0, exp_ovf = 0, exp_unk = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds one message with filler in ignored fields and queues its expected decode
    task automatic add_msg(input logic [7:0] t, input logic [15:0] loc, input logic [63:0] r,
                           input logic [63:0] nr, input logic [31:0] sh, input logic [31:0] pr,
                           input logic bs, input bit expect_out, input logic [1:0] chan);
        byte_q_t m;
        int len;
        exp_t e;
        case (t)
            8'h41: len = 36; 8'h46: len = 40; 8'h44: len = 19;
            8'h45: len = 31; 8'h58: len = 23; default: len = 35;
        endcase
        for (int i = 0; i < len; i++) m.push_back(8'(i * 13 + 5));
        m[0] = t;
        m[1] = loc[15:8];
        m[2] = loc[7:0];
        for (int k = 0; k < 8; k++) m[11+k] = r[63-8*k -: 8];
        if (t == 8'h41 || t == 8'h46) begin
            m[19] = bs ? 8'h42 : 8'h53;
            for (int k = 0; k < 4; k++) begin
                m[20+k] = sh[31-8*k -: 8];
                m[32+k] = pr[31-8*k -: 8];
            end
        end else if (t == 8'h45 || t == 8'h58) begin
            for (int k = 0; k < 4; k++) m[19+k] = sh[31-8*k -: 8];
        end else if (t == 8'h55) begin
            for (int k = 0; k < 8; k++) m[19+k] = nr[63-8*k -: 8];
            for (int k = 0; k < 4; k++) begin
                m[27+k] = sh[31-8*k -: 8];
                m[31+k] = pr[31-8*k -: 8];
            end
        end
        foreach (m[i]) pkt.push_back(m[i]);
        if (expect_out) begin
            case (t)
                8'h41, 8'h46: e.kind = 3'd1;
                8'h44:        e.kind = 3'd2;
                8'h45:        e.kind = 3'd3;
                8'h58:        e.kind = 3'd4;
                default:      e.kind = 3'd5;
            endcase
            e.rf   = r;
            e.nrf  = (t == 8'h55) ? nr : 64'd0;
            e.loc  = loc;
            e.sh   = (t == 8'h44) ? 32'd0 : sh;
            e.pr   = (t == 8'h41 || t == 8'h46 || t == 8'h55) ? pr : 32'd0;
            e.bs   = (t == 8'h41 || t == 8'h46) ? bs : 1'b0;
            e.chan = chan;
            sb.push_back(e);
            exp_valid++;
        end
    endtask

    task automatic send_pkt(input int lost_at);
        foreach (pkt[i]) begin
            @(negedge clk);
            dataIn       = pkt[i];
            dataValidIn  = 1'b1;
            packetLostIn = (i == lost_at);
        end
        @(negedge clk);
        dataValidIn  = 1'b0;
        packetLostIn = 1'b0;
        dataIn       = 8'h00;
        repeat (3) @(negedge clk);
        pkt.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        chk({tag, "_drained"}, 256'(sb.size()), 256'd0);
        chk({tag, "_valids"}, 256'(n_valid), 256'(exp_valid));
        chk({tag, "_trunc"}, 256'(n_trunc), 256'(exp_trunc));
        chk({tag, "_ovf"}, 256'(n_ovf), 256'(exp_ovf));
        chk({tag, "_unknown"}, 256'(n_unk), 256'(exp_unk));
    endtask

    // Output monitor: pops the scoreboard on every valid and counts error pulse cycles
    always @(negedge clk) begin
        int nv;
        logic [2:0] k;
        exp_t e;
        if (!rst) begin
            nv = int'(addValidOut) + int'(delValidOut) + int'(execValidOut)
               + int'(cancelValidOut) + int'(replaceValidOut);
            n_trunc += int'(errTruncOut);
            n_ovf   += int'(errOverflowOut);
            n_unk   += int'(errUnknownOut);
            if (nv != 0) begin
                n_valid++;
                chk("one_hot_valid", 256'(nv), 256'd1);
                k = addValidOut ? 3'd1 : delValidOut ? 3'd2 : execValidOut ? 3'd3 :
                    cancelValidOut ? 3'd4 : 3'd5;
                if (sb.size() == 0) begin
                    chk("unexpected_valid_kind", 256'(k), 256'd0);
                end else begin
                    e = sb.pop_front();
                    chk("kind", 256'(k), 256'(e.kind));
                    chk("ref", 256'(refNumOut), 256'(e.rf));
                    chk("new_ref", 256'(newRefNumOut), 256'(e.nrf));
                    chk("locate", 256'(locateOut), 256'(e.loc));
                    chk("shares", 256'(sharesOut), 256'(e.sh));
                    chk("price", 256'(priceOut), 256'(e.pr));
                    chk("buy_sell", 256'(buySellOut), 256'(e.bs));
                    chk("chan", 256'(chanOut), 256'(e.chan));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; dataIn = 8'h00; dataValidIn = 1'b0; packetLostIn = 1'b0;
        locateTableIn = {16'h0, 16'h0, 16'h0, 16'hBE42};
        locateEnIn    = 4'b0001;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 256'({addValidOut, delValidOut, execValidOut, cancelValidOut,
            replaceValidOut, refNumOut, newRefNumOut, locateOut, sharesOut, priceOut,
            buySellOut, chanOut, errTruncOut, errOverflowOut, errUnknownOut}), 256'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 22 x {A, D, E} back-to-back in one 1892-byte packet
        for (int i = 0; i < 22; i++) begin
            add_msg(8'h41, 16'hBE42, 64'hDEFB1673DEFB1673, 64'd0, 32'd45, 32'h0022FEFC, 1'b1, 1'b1, 2'd0);
            add_msg(8'h44, 16'hBE42, 64'h0000_0000_0000_1000 + 64'(i), 64'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd0);
            add_msg(8'h45, 16'hBE42, 64'h0000_0000_0000_2000 + 64'(i), 64'd0, 32'(100 + i), 32'd0, 1'b0, 1'b1, 2'd0);
        end
        chk("pkt_len_1892", 256'(pkt.size()), 256'd1892);
        send_pkt(-1);
        drain("axde");

        // Replace then cancel back-to-back, then an F with sell side
        add_msg(8'h55, 16'hBE42, 64'h1111111111111111, 64'h2222222222222222, 32'd64, 32'h0001E240, 1'b0, 1'b1, 2'd0);
        add_msg(8'h58, 16'hBE42, 64'h3333333333333333, 64'd0, 32'd10, 32'd0, 1'b0, 1'b1, 2'd0);
        add_msg(8'h46, 16'hBE42, 64'h0123456789ABCDEF, 64'd0, 32'd7, 32'h00000100, 1'b0, 1'b1, 2'd0);
        send_pkt(-1);
        drain("uxf");

        // Filter: disabled entry never matches; lowest enabled matching entry wins
        locateTableIn = {16'h0001, 16'h0001, 16'h0001, 16'hBE42};
        locateEnIn    = 4'b0110;
        add_msg(8'h41, 16'hBE42, 64'hAAAA, 64'd0, 32'd1, 32'd2, 1'b1, 1'b0, 2'd0);
        add_msg(8'h41, 16'h0001, 64'hBBBB, 64'd0, 32'd3, 32'd4, 1'b1, 1'b1, 2'd1);
        send_pkt(-1);
        locateEnIn = 4'b0000;
        add_msg(8'h44, 16'h0001, 64'hCCCC, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
        send_pkt(-1);
        drain("filter");

        // Truncation after byte 20 of an A, then a clean packet
        locateTableIn = {16'h0, 16'h0, 16'h0, 16'hBE42};
        locateEnIn    = 4'b0001;
        add_msg(8'h41, 16'hBE42, 64'hDDDD, 64'd0, 32'd5, 32'd6, 1'b1, 1'b0, 2'd0);
        while (pkt.size() > 20) void'(pkt.pop_back());
        send_pkt(-1);
        exp_trunc++;
        add_msg(8'h41, 16'hBE42, 64'hEEEE, 64'd0, 32'd8, 32'd9, 1'b0, 1'b1, 2'd0);
        send_pkt(-1);
        drain("trunc");

        // Overflow: 2100 bytes of A; the 57th message straddles byte 2049
        for (int i = 0; i < 59; i++)
            add_msg(8'h41, 16'hBE42, 64'(i + 500), 64'd0, 32'(i), 32'(i * 3), 1'b1, i < 56, 2'd0);
        while (pkt.size() > 2100) void'(pkt.pop_back());
        send_pkt(-1);
        exp_ovf++;
        drain("overflow");

        // Unknown type at packet start drops the rest of the packet
        pkt.push_back(8'h53);
        add_msg(8'h41, 16'hBE42, 64'hFFFF, 64'd0, 32'd1, 32'd1, 1'b1, 1'b0, 2'd0);
        send_pkt(-1);
        exp_unk++;
        drain("unknown");

        // Packet loss in the middle of a D, then a normal packet
        add_msg(8'h44, 16'hBE42, 64'h4444, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
        send_pkt(10);
        add_msg(8'h45, 16'hBE42, 64'h5555, 64'd0, 32'd77, 32'd0, 1'b0, 1'b1, 2'd0);
        send_pkt(-1);
        drain("lost");

        // Reset mid-message discards the partial message
        add_msg(8'h41, 16'hBE42, 64'h6666, 64'd0, 32'd1, 32'd1, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dataIn      = pkt[i];
            dataValidIn = 1'b1;
        end
        pkt.delete();
        @(negedge clk);
        rst = 1'b1;
        dataValidIn = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", 256'({addValidOut, delValidOut, execValidOut, cancelValidOut,
            replaceValidOut, refNumOut, locateOut, sharesOut, priceOut}), 256'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        add_msg(8'h41, 16'hBE42, 64'h7777, 64'd0, 32'd12, 32'd34, 1'b1, 1'b1, 2'd0);
        send_pkt(-1);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
